// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package stage_if_pkg;

    localparam logic [31:0] NopInstr         = 32'h0000_0013;
    localparam logic [31:0] DefaultResetAddr = 32'h8000_0000;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2,
        StFault   = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        access_fault;
        logic        addr_misaligned;
    } fetch_entry_t;

    localparam int unsigned EntryW = $bits(fetch_entry_t);

    function automatic fetch_entry_t make_entry(input logic [31:0] instr, input logic [31:0] pc,
                                                input logic access_fault,
                                                input logic addr_misaligned);
        fetch_entry_t e;
        e.instr           = instr;
        e.pc              = pc;
        e.access_fault    = access_fault;
        e.addr_misaligned = addr_misaligned;
        return e;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry output slot plus one-entry skid for the fetch/decode handoff.
module if_skid_buffer
    import stage_if_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              push_i,
    input  logic [EntryW-1:0] push_entry_i,
    output logic              slot_free_o,
    output logic              consume_o,
    output logic              valid_o,
    output logic [EntryW-1:0] entry_o
);

    fetch_entry_t slot_q, slot_d, skid_q, skid_d;
    logic         valid_q, valid_d, skid_valid_q, skid_valid_d;

    assign consume_o   = valid_q & ~stall_i;
    assign slot_free_o = ~valid_q | consume_o;
    assign valid_o     = valid_q;
    assign entry_o     = slot_q;

    always_comb begin
        slot_d       = slot_q;
        skid_d       = skid_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume_o) begin
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                slot_d = skid_q;
            end
        end

        // A push during flush is the misaligned-redirect entry, which lands in the emptied slot.
        if (push_i) begin
            if (flush_i || slot_free_o) begin
                slot_d  = fetch_entry_t'(push_entry_i);
                valid_d = 1'b1;
            end else begin
                skid_d       = fetch_entry_t'(push_entry_i);
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q       <= '0;
            skid_q       <= '0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            skid_q       <= skid_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: owns the PC, runs single-outstanding instruction bus cycles
// and feeds decode through a skid-buffered output slot.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DefaultResetAddr
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_dat_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_target_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        e_inst_access_fault_o,
    output logic        e_inst_addr_misaligned_o
);

    if_state_e         state_q, state_d;
    logic [31:0]       pc_q, pc_d, addr_q, addr_d;
    logic              bus_active, resp, target_misaligned;
    logic              push, slot_free, consume;
    fetch_entry_t      push_entry, slot_entry;
    logic [EntryW-1:0] slot_bits;

    assign bus_active        = (state_q == StFetch) || (state_q == StDiscard);
    assign resp              = bus_active & (iport_ack_i | iport_err_i);
    assign target_misaligned = |pc_target_i[1:0];

    assign iport_cyc_o  = bus_active & ~rst_i;
    assign iport_stb_o  = iport_cyc_o;
    assign iport_addr_o = iport_cyc_o ? addr_q : 32'h0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        push_entry = make_entry(iport_dat_i, addr_q, 1'b0, 1'b0);

        case (state_q)
            StFetch: begin
                if (iport_ack_i) begin
                    push   = 1'b1;
                    pc_d   = addr_q + 32'd4;
                    addr_d = addr_q + 32'd4;
                    if (!slot_free) begin
                        state_d = StHold;
                    end
                end else if (iport_err_i) begin
                    push       = 1'b1;
                    push_entry = make_entry(NopInstr, addr_q, 1'b1, 1'b0);
                    state_d    = StFault;
                end
            end
            StHold: begin
                if (consume) begin
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                // pc_q may hold a misaligned target whose entry was already delivered.
                if (resp) begin
                    addr_d  = pc_q;
                    state_d = (|pc_q[1:0]) ? StFault : StFetch;
                end
            end
            default: state_d = StFault;
        endcase

        if (flush_i) begin
            pc_d   = pc_target_i;
            addr_d = pc_target_i;
            push   = target_misaligned;
            push_entry = make_entry(NopInstr, pc_target_i, 1'b0, 1'b1);
            if (bus_active && !resp) begin
                state_d = StDiscard;
                addr_d  = addr_q;
            end else begin
                state_d = target_misaligned ? StFault : StFetch;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            pc_q    <= RESET_ADDR;
            addr_q  <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    if_skid_buffer u_skid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .slot_free_o  (slot_free),
        .consume_o    (consume),
        .valid_o      (valid_o),
        .entry_o      (slot_bits)
    );

    assign slot_entry               = fetch_entry_t'(slot_bits);
    assign instruction_o            = slot_entry.instr;
    assign pc_o                     = slot_entry.pc;
    assign e_inst_access_fault_o    = valid_o & slot_entry.access_fault;
    assign e_inst_addr_misaligned_o = valid_o & slot_entry.addr_misaligned;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: scoreboarded bus/output streams plus a redirect table.
module tb_stage_if;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] iport_addr_o;
    logic        iport_cyc_o, iport_stb_o;
    logic [31:0] iport_dat_i;
    logic        iport_ack_i, iport_err_i;
    logic        stall_i, flush_i;
    logic [31:0] pc_target_i;
    logic [31:0] instruction_o, pc_o;
    logic        valid_o, e_inst_access_fault_o, e_inst_addr_misaligned_o;

    int checks = 0;
    int errors = 0;

    stage_if #(.RESET_ADDR(32'h8000_0000)) dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .iport_addr_o             (iport_addr_o),
        .iport_cyc_o              (iport_cyc_o),
        .iport_stb_o              (iport_stb_o),
        .iport_dat_i              (iport_dat_i),
        .iport_ack_i              (iport_ack_i),
        .iport_err_i              (iport_err_i),
        .stall_i                  (stall_i),
        .flush_i                  (flush_i),
        .pc_target_i              (pc_target_i),
        .instruction_o            (instruction_o),
        .pc_o                     (pc_o),
        .valid_o                  (valid_o),
        .e_inst_access_fault_o    (e_inst_access_fault_o),
        .e_inst_addr_misaligned_o (e_inst_addr_misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: data = address; answers only while grants remain, after ack_delay cycles.
    int unsigned grant_total = 0;
    int unsigned grant_used = 0;
    int unsigned ack_delay = 0;
    int unsigned age = 0;
    logic        err_en;
    logic [31:0] err_addr;
    logic        resp;

    always_comb begin
        resp        = iport_cyc_o && (grant_used < grant_total) && (age >= ack_delay);
        iport_err_i = resp && err_en && (iport_addr_o == err_addr);
        iport_ack_i = resp && !iport_err_i;
        iport_dat_i = iport_addr_o;
    end

    always @(posedge clk_i) begin
        if (resp) grant_used <= grant_used + 1;
        if (!iport_cyc_o || resp) age <= 0;
        else age <= age + 1;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        af;
        logic        am;
    } exp_t;

    exp_t        out_q[$];
    logic [31:0] req_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_word(input logic [31:0] a);
        out_q.push_back('{pc: a, instr: a, af: 1'b0, am: 1'b0});
    endtask

    task automatic exp_fault(input logic [31:0] a);
        out_q.push_back('{pc: a, instr: Nop, af: 1'b1, am: 1'b0});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every bus response and every consumed entry must match the queues.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("stb_eq_cyc", {31'b0, iport_stb_o}, {31'b0, iport_cyc_o});
            if (iport_cyc_o && (iport_ack_i || iport_err_i)) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_extra: got %h expected none", iport_addr_o);
                end else begin
                    chk("req_addr", iport_addr_o, req_q.pop_front());
                end
            end
            if (valid_o && !stall_i) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_extra: got pc %h expected none", pc_o);
                end else begin
                    exp_t e;
                    e = out_q.pop_front();
                    chk("out_pc", pc_o, e.pc);
                    chk("out_instr", instruction_o, e.instr);
                    chk("out_flags", {30'b0, e_inst_access_fault_o, e_inst_addr_misaligned_o},
                        {30'b0, e.af, e.am});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] target;
        logic        valid;
        logic [31:0] pc;
        logic        am;
        logic        cyc;
        logic [31:0] addr;
    } row_t;

    row_t rows[6];

    initial begin
        // Redirects while stalled with the bus starved: FAULT -> mis -> fetch -> discard chain.
        rows[0] = '{32'h0000_0102, 1'b1, 32'h0000_0102, 1'b1, 1'b0, 32'h0};
        rows[1] = '{32'h0000_0200, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0200};
        rows[2] = '{32'h0000_0301, 1'b1, 32'h0000_0301, 1'b1, 1'b1, 32'h0000_0200};
        rows[3] = '{32'h0000_0400, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0200};
        rows[4] = '{32'h0000_0103, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0200};
        rows[5] = '{32'h0000_0500, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0200};

        rst_i       = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        pc_target_i = 32'h0;
        err_en      = 1'b1;
        err_addr    = 32'h8000_0010;

        repeat (2) tick();
        @(negedge clk_i);
        chk("rst_cyc", {31'b0, iport_cyc_o}, 32'h0);
        chk("rst_addr", iport_addr_o, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instruction_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_flags", {30'b0, e_inst_access_fault_o, e_inst_addr_misaligned_o}, 32'h0);

        // Streaming, stall into skid, then a bus error at 8000_0010.
        for (int i = 0; i < 5; i++) req_q.push_back(32'h8000_0000 + 32'(i * 4));
        for (int i = 0; i < 4; i++) exp_word(32'h8000_0000 + 32'(i * 4));
        exp_fault(32'h8000_0010);
        grant_total = 5;

        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("first_req", iport_addr_o, 32'h8000_0000);
        chk("first_valid", {31'b0, valid_o}, 32'h0);
        tick();
        @(negedge clk_i);
        chk("lat_valid", {31'b0, valid_o}, 32'h1);
        chk("lat_pc", pc_o, 32'h8000_0000);
        tick();
        stall_i = 1'b1;
        @(negedge clk_i);
        chk("stall_pc", pc_o, 32'h8000_0004);
        tick();
        @(negedge clk_i);
        chk("hold_cyc", {31'b0, iport_cyc_o}, 32'h0);
        chk("hold_pc", pc_o, 32'h8000_0004);
        chk("hold_instr", instruction_o, 32'h8000_0004);
        tick();
        tick();
        stall_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("fault_valid", {31'b0, valid_o}, 32'h1);
        chk("fault_af", {31'b0, e_inst_access_fault_o}, 32'h1);
        chk("fault_pc", pc_o, 32'h8000_0010);
        chk("fault_instr", instruction_o, Nop);
        chk("fault_cyc", {31'b0, iport_cyc_o}, 32'h0);
        tick();
        @(negedge clk_i);
        chk("fault_idle_cyc", {31'b0, iport_cyc_o}, 32'h0);
        chk("fault_idle_valid", {31'b0, valid_o}, 32'h0);
        tick();

        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            flush_i     = 1'b1;
            pc_target_i = rows[i].target;
            tick();
            flush_i = 1'b0;
            @(negedge clk_i);
            chk($sformatf("row%0d_valid", i), {31'b0, valid_o}, {31'b0, rows[i].valid});
            chk($sformatf("row%0d_am", i), {31'b0, e_inst_addr_misaligned_o}, {31'b0, rows[i].am});
            chk($sformatf("row%0d_cyc", i), {31'b0, iport_cyc_o}, {31'b0, rows[i].cyc});
            if (rows[i].cyc) chk($sformatf("row%0d_addr", i), iport_addr_o, rows[i].addr);
            if (rows[i].valid) begin
                chk($sformatf("row%0d_pc", i), pc_o, rows[i].pc);
                chk($sformatf("row%0d_instr", i), instruction_o, Nop);
            end
            tick();
        end

        // Discarded response at 0200, then fetching resumes at the last target.
        stall_i = 1'b0;
        req_q.push_back(32'h0000_0200);
        req_q.push_back(32'h0000_0500);
        req_q.push_back(32'h0000_0504);
        exp_word(32'h0000_0500);
        exp_word(32'h0000_0504);
        grant_total += 3;
        tick();
        @(negedge clk_i);
        chk("disc_resume_addr", iport_addr_o, 32'h0000_0500);
        chk("disc_resume_valid", {31'b0, valid_o}, 32'h0);
        repeat (3) tick();

        // Flush to 0100 while the 0508 request waits for a delayed ack.
        flush_i     = 1'b1;
        pc_target_i = 32'h0000_0100;
        ack_delay   = 3;
        req_q.push_back(32'h0000_0508);
        req_q.push_back(32'h0000_0100);
        req_q.push_back(32'h0000_0104);
        exp_word(32'h0000_0100);
        exp_word(32'h0000_0104);
        grant_total += 3;
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("delay_cyc", {31'b0, iport_cyc_o}, 32'h1);
        chk("delay_addr", iport_addr_o, 32'h0000_0508);
        chk("delay_valid", {31'b0, valid_o}, 32'h0);
        tick();
        ack_delay = 0;
        @(negedge clk_i);
        chk("delay_ack_addr", iport_addr_o, 32'h0000_0508);
        tick();
        @(negedge clk_i);
        chk("redirect_addr", iport_addr_o, 32'h0000_0100);
        chk("redirect_valid", {31'b0, valid_o}, 32'h0);
        repeat (3) tick();

        // Flush coinciding with ack on 0108, then wrap past FFFF_FFFC.
        flush_i     = 1'b1;
        pc_target_i = 32'hFFFF_FFF8;
        req_q.push_back(32'h0000_0108);
        req_q.push_back(32'hFFFF_FFF8);
        req_q.push_back(32'hFFFF_FFFC);
        req_q.push_back(32'h0000_0000);
        exp_word(32'hFFFF_FFF8);
        exp_word(32'hFFFF_FFFC);
        exp_word(32'h0000_0000);
        grant_total += 4;
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("coincide_addr", iport_addr_o, 32'hFFFF_FFF8);
        chk("coincide_valid", {31'b0, valid_o}, 32'h0);
        tick();
        tick();
        @(negedge clk_i);
        chk("wrap_addr", iport_addr_o, 32'h0000_0000);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        tick();
        tick();
        @(negedge clk_i);
        chk("drain_out", out_q.size(), 32'h0);
        chk("drain_req", req_q.size(), 32'h0);
        chk("end_valid", {31'b0, valid_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction Fetch stage of the pipeline. It is the producer end of the fetch/decode interface: it owns the PC, runs single-outstanding instruction-port bus cycles, and presents `instruction_o`/`pc_o`/`valid_o` to the decode stage. It honours backend `stall_i` through a one-entry skid buffer and redirects on `flush_i`. It also raises fetch-side exceptions for the exception unit.

## Interface
- `RESET_ADDR`, default 32'h8000_0000: PC value after reset.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, synchronous and active-high.
- `iport_addr_o` output 32: fetch address; stable while `iport_cyc_o` is high.
- `iport_cyc_o` output 1: bus cycle active.
- `iport_stb_o` output 1: strobe; always equal to `iport_cyc_o`.
- `iport_dat_i` input 32: instruction word, sampled on ack.
- `iport_ack_i` input 1: transfer complete; may be combinational in the request cycle.
- `iport_err_i` input 1: bus error; mutually exclusive with ack.
- `stall_i` input 1: decode cannot accept this cycle.
- `flush_i` input 1: redirect request.
- `pc_target_i` input 32: redirect target, valid when `flush_i` is high.
- `instruction_o` output 32: fetched word.
- `pc_o` output 32: address of `instruction_o`.
- `valid_o` output 1: output slot holds an entry.
- `e_inst_access_fault_o` output 1: qualifies the current entry as an access fault.
- `e_inst_addr_misaligned_o` output 1: qualifies the current entry as a misaligned fetch.

## Operation
- Internal registers:
  - `pc_q`: next address to fetch.
  - `addr_q`: address in flight.
  - Output slot.
  - Skid entry.
  - FSM: FETCH, HOLD, DISCARD, FAULT.
- Consume = `valid_o & ~stall_i`. The slot is free when `~valid_o` or when consume is true.
- **FETCH**
  - Bus cycle asserted with `addr_q`.
  - On ack without flush:
    - If the slot is free, the slot loads {dat, `addr_q`} and `pc_q`/`addr_q` advance by 4. The next request is issued the following cycle.
    - If the slot is not free, the word goes to the skid entry and the FSM moves to HOLD with the bus idle.
  - On err: load the slot (or skid) with a fault entry, go to FAULT with the bus idle.
- **HOLD**
  - Bus idle.
  - On consume, the skid moves to the slot and the FSM returns to FETCH.
- **FAULT**
  - No fetches are issued.
  - The fault entry stays in the slot until consumed. A fault held in the skid moves to the slot on consume, as in HOLD.
  - The FSM stays in FAULT until `flush_i`.
- **DISCARD**
  - Entered when `flush_i` arrives while a bus cycle is outstanding and no ack/err occurs that cycle.
  - `cyc`/`stb` stay high on the old `addr_q` until ack/err.
  - The response is dropped, then the FSM goes to FETCH with `addr_q` = `pc_q`.
  - A further flush while in DISCARD overwrites `pc_q`.
- **`flush_i`** (any state, highest priority after `rst_i`)
  - Clears `valid_o`, the skid, and both exception flags.
  - Loads `pc_q` with `pc_target_i`.
  - If ack/err coincides with the flush, the data is dropped and the FSM goes directly to FETCH.
- **Misaligned target** (`pc_target_i[1:0]` ≠ 0)
  - No bus cycle is issued.
  - The next cycle the slot holds `pc_o` = target, `instruction_o` = NOP (32'h0000_0013), and `e_inst_addr_misaligned_o` = 1. The FSM goes to FAULT.
- **Fault entry contents**: `instruction_o` = NOP, `pc_o` = faulting address.
- **Arithmetic**: PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- **Reset** (`rst_i` high at a clock edge):
  - All outputs are 0, `valid_o` = 0, state = FETCH.
  - `pc_q` = `addr_q` = `RESET_ADDR`.
  - `iport_cyc_o` = 0 during reset.
- First request: the cycle after `rst_i` deasserts.
- Reset mid-transaction drops the outstanding cycle immediately. The bus slave tolerates `cyc` deassertion.
- Latency: ack in cycle N → `valid_o` high in N+1.
- Throughput: with a combinational ack, one instruction per cycle with no bubbles.
- Redirect: flush in cycle N with a free bus → request to the target in N+1.
- Stall: the slot is held stable (`instruction_o`, `pc_o`, flags unchanged) while `stall_i` and `valid_o` are both high.
- At most one bus cycle is outstanding. `iport_addr_o` never changes while `cyc` is high.

## Structure
- Shared package holds:
  - The NOP encoding constant.
  - The default reset address.
  - The FSM state encoding (2-bit).
  - The fetch-entry bundle (instr, pc, 2 exception flags).
- One natural sub-module: `if_skid_buffer`, the one-entry output slot plus skid with valid/stall semantics. The parent owns the FSM, PC and bus.

## Test plan
- **Reset then streaming.** Release `rst_i`; the memory acks combinationally with data = address.
  - Requests go to 8000_0000, 8000_0004, …
  - `valid_o` rises the cycle after the first request and holds one entry per cycle.
- **Stall with skid.** Assert `stall_i` for 3 cycles while an ack arrives.
  - The slot holds 8000_0004 and the skid holds 8000_0008; the bus goes idle.
  - After release, the outputs advance in order with no loss or duplication.
- **Flush while a request is outstanding.** Flush to 0000_0100 while ack is delayed 3 cycles.
  - `cyc` stays high on the old address until ack; the returned data never appears on the outputs.
  - The next request goes to 0000_0100.
- **Bus error.** Assert `iport_err_i` at 8000_0010.
  - `valid_o` = 1, `e_inst_access_fault_o` = 1, `pc_o` = 8000_0010, `instruction_o` = 0000_0013.
  - No further requests until flush.
- **Misaligned redirect.** Flush to 0000_0102.
  - No bus cycle is issued; `e_inst_addr_misaligned_o` = 1 with `pc_o` = 0000_0102.
  - A following flush to 0000_0200 resumes fetching.
- **Flush coinciding with ack, and wrap-around.**
  - Flush in the same cycle as ack → data is dropped and the target is fetched the next cycle.
  - Fetch at FFFF_FFFC → the next request is 0000_0000.
